// File: rtl/seq_step_controller.sv
// seq_step_controller
// Decides when the HEX digit-sequence datapath advances and in which direction:
// free-running every RATE cycles (RUN) or one step per pushbutton press (SINGLE).
// Tracks the current sequence index and flags wrap-around.
//
// Ports:
//   i_clk       system clock, rising-edge active
//   i_reset     synchronous active-low reset (0 = reset)
//   i_run_sw    1 = automatic stepping, 0 = manual/idle (asynchronous)
//   i_dir_sw    0 = forward, 1 = reverse (asynchronous)
//   i_step_key  active-low pushbutton, a press requests one manual step
//   o_step_en   one-cycle pulse, datapath advances this cycle
//   o_step_dir  direction of the most recent step (0 fwd, 1 rev)
//   o_seq_idx   current sequence position, 0..SEQ_LEN-1
//   o_wrap      one-cycle pulse with o_step_en when the index wraps
//   o_state     controller state: 00 IDLE, 01 RUN, 10 SINGLE
module seq_step_controller #(
    parameter int unsigned RATE    = 4,
    parameter int unsigned SEQ_LEN = 5,
    parameter int unsigned IDX_W   = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run_sw,
    input  logic             i_dir_sw,
    input  logic             i_step_key,
    output logic             o_step_en,
    output logic             o_step_dir,
    output logic [IDX_W-1:0] o_seq_idx,
    output logic             o_wrap,
    output logic [1:0]       o_state
);

    localparam int unsigned PRE_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SINGLE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_nxt;
    logic             w_step;

    // Two-flop synchronisers plus one extra key register for press detection
    logic r_run_s1, r_run_s;
    logic r_dir_s1, r_dir_s;
    logic r_key_s1, r_key_s, r_key_d;
    logic w_key_evt;

    logic             r_step_en;
    logic             r_step_dir;
    logic [IDX_W-1:0] r_idx;
    logic             r_wrap;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_wrap_nxt;

    // Input synchronisers; key idles high so no press is seen out of reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_run_s1 <= 1'b0;
            r_run_s  <= 1'b0;
            r_dir_s1 <= 1'b0;
            r_dir_s  <= 1'b0;
            r_key_s1 <= 1'b1;
            r_key_s  <= 1'b1;
            r_key_d  <= 1'b1;
        end else begin
            r_run_s1 <= i_run_sw;
            r_run_s  <= r_run_s1;
            r_dir_s1 <= i_dir_sw;
            r_dir_s  <= r_dir_s1;
            r_key_s1 <= i_step_key;
            r_key_s  <= r_key_s1;
            r_key_d  <= r_key_s;
        end
    end

    // Press = synced key falling edge; a held key yields one event only
    assign w_key_evt = r_key_d & ~r_key_s;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, prescaler and step request
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pre_nxt = '0;
                // RUN wins over a coincident press; the press is dropped
                if (r_run_s) begin
                    w_state_nxt = ST_RUN;
                end else if (w_key_evt) begin
                    w_state_nxt = ST_SINGLE;
                    w_step      = 1'b1;
                end
            end
            ST_RUN: begin
                // Leaving RUN suppresses a step even at terminal count
                if (!r_run_s) begin
                    w_state_nxt = ST_IDLE;
                    w_pre_nxt   = '0;
                end else if (r_pre == PRE_LAST) begin
                    w_pre_nxt = '0;
                    w_step    = 1'b1;
                end else begin
                    w_pre_nxt = r_pre + PRE_W'(1);
                end
            end
            ST_SINGLE: begin
                w_state_nxt = ST_IDLE;
                w_pre_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pre_nxt   = '0;
            end
        endcase
    end

    // Index arithmetic with wrap in either direction
    always_comb begin
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        if (w_step) begin
            if (r_dir_s) begin
                if (r_idx == '0) begin
                    w_idx_nxt  = IDX_LAST;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end else begin
                if (r_idx >= IDX_LAST) begin
                    w_idx_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
        end
    end

    // Datapath registers; step outputs rise on the same edge as the index update
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pre      <= '0;
            r_step_en  <= 1'b0;
            r_step_dir <= 1'b0;
            r_idx      <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_pre     <= w_pre_nxt;
            r_step_en <= w_step;
            r_wrap    <= w_wrap_nxt;
            r_idx     <= w_idx_nxt;
            if (w_step) begin
                r_step_dir <= r_dir_s;
            end
        end
    end

    assign o_step_en  = r_step_en;
    assign o_step_dir = r_step_dir;
    assign o_seq_idx  = r_idx;
    assign o_wrap     = r_wrap;
    assign o_state    = r_state;

endmodule
